// File: rtl/spi_master_frontend.sv
// Single-byte-address SPI master front end (mode 0, MSB first).
// Raw cs_req/MISO are synchronized and debounced before use by the transaction FSM.

module spi_conditioner #(
  parameter int COUNTERWIDTH = 3,
  parameter int WAITTIME     = 3
) (
  input  logic CLK,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic                    sync1;
  logic                    sync2;
  logic [COUNTERWIDTH-1:0] cnt;

  // Edge pulses are registered together with the level so they coincide with its change.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == COUNTERWIDTH'(WAITTIME - 1)) begin
        level <= sync2;
        cnt   <= '0;
        rise  <= sync2;
        fall  <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

module spi_master_frontend #(
  parameter int COUNTERWIDTH = 3,
  parameter int WAITTIME     = 3,
  parameter int SCLK_DIV     = 8
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       cs_req,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic       MISO,
  output logic       MOSI,
  output logic       SCLK,
  output logic       CS,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done
);

  localparam int DIVW = $clog2(SCLK_DIV + 1);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_LOAD_ADDR  = 3'd1;
  localparam logic [2:0] ST_SHIFT_ADDR = 3'd2;
  localparam logic [2:0] ST_LOAD_DATA  = 3'd3;
  localparam logic [2:0] ST_SHIFT_DATA = 3'd4;
  localparam logic [2:0] ST_READ_DATA  = 3'd5;
  localparam logic [2:0] ST_DONE       = 3'd6;

  logic [2:0]      state;
  logic            sclk_r;
  logic [DIVW-1:0] half_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic [7:0]      capture;
  logic [7:0]      addr_hold;
  logic [7:0]      wdata_hold;
  logic [7:0]      mux_out;
  logic            mux_sel;
  logic            half_end;
  logic            shifting;

  logic            cs_level_unused;
  logic            cs_rise;
  logic            cs_fall_unused;
  logic            miso_c;
  logic            miso_rise_unused;
  logic            miso_fall_unused;

  spi_conditioner #(.COUNTERWIDTH(COUNTERWIDTH), .WAITTIME(WAITTIME)) u_cs_cond (
    .CLK   (CLK),
    .reset (reset),
    .raw   (cs_req),
    .level (cs_level_unused),
    .rise  (cs_rise),
    .fall  (cs_fall_unused)
  );

  spi_conditioner #(.COUNTERWIDTH(COUNTERWIDTH), .WAITTIME(WAITTIME)) u_miso_cond (
    .CLK   (CLK),
    .reset (reset),
    .raw   (MISO),
    .level (miso_c),
    .rise  (miso_rise_unused),
    .fall  (miso_fall_unused)
  );

  assign mux_sel  = (state == ST_LOAD_DATA);
  assign mux_out  = mux_sel ? wdata_hold : addr_hold;
  assign half_end = (half_cnt == DIVW'(SCLK_DIV - 1));
  assign shifting = (state == ST_SHIFT_ADDR) || (state == ST_SHIFT_DATA) ||
                    (state == ST_READ_DATA);

  // The load cycle already drives the first bit, so it counts as the first low cycle.
  always_comb begin
    MOSI = 1'b0;
    if ((state == ST_LOAD_ADDR) || (state == ST_LOAD_DATA)) begin
      MOSI = mux_out[7];
    end else if ((state == ST_SHIFT_ADDR) || (state == ST_SHIFT_DATA)) begin
      MOSI = shreg[7];
    end
  end

  assign SCLK = sclk_r;
  assign CS   = (state == ST_IDLE) || (state == ST_DONE);
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      sclk_r     <= 1'b0;
      half_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      capture    <= '0;
      addr_hold  <= '0;
      wdata_hold <= '0;
      rdata      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cs_rise) begin
            addr_hold  <= addr;
            wdata_hold <= wdata;
            state      <= ST_LOAD_ADDR;
          end
        end
        ST_LOAD_ADDR, ST_LOAD_DATA: begin
          shreg    <= mux_out;
          half_cnt <= DIVW'(1);
          bit_cnt  <= '0;
          sclk_r   <= 1'b0;
          state    <= (state == ST_LOAD_ADDR) ? ST_SHIFT_ADDR : ST_SHIFT_DATA;
        end
        ST_DONE: begin
          sclk_r <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          if (shifting) begin
            if (half_end) begin
              half_cnt <= '0;
              sclk_r   <= ~sclk_r;
              if (sclk_r) begin
                // Read data is taken at the end of the high half, just before the fall.
                if (state == ST_READ_DATA) begin
                  capture <= {capture[6:0], miso_c};
                  if (bit_cnt == 3'd7) begin
                    rdata <= {capture[6:0], miso_c};
                  end
                end else begin
                  shreg <= {shreg[6:0], 1'b0};
                end
                if (bit_cnt == 3'd7) begin
                  bit_cnt <= '0;
                  if (state == ST_SHIFT_ADDR) begin
                    state <= addr_hold[7] ? ST_READ_DATA : ST_LOAD_DATA;
                  end else begin
                    state <= ST_DONE;
                  end
                end else begin
                  bit_cnt <= bit_cnt + 3'd1;
                end
              end
            end else begin
              half_cnt <= half_cnt + 1'b1;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_frontend.sv
// Scoreboard bench for spi_master_frontend: expected MOSI streams and rdata are queued
// at request time and checked by a monitor whenever the DUT pulses done.

module tb_spi_master_frontend;

  localparam int COUNTERWIDTH = 3;
  localparam int WAITTIME     = 3;
  localparam int SCLK_DIV     = 8;

  logic       CLK = 1'b0;
  logic       reset;
  logic       cs_req;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       MISO;
  logic       MOSI;
  logic       SCLK;
  logic       CS;
  logic [7:0] rdata;
  logic       busy;
  logic       done;

  always #5 CLK = ~CLK;

  spi_master_frontend #(
    .COUNTERWIDTH (COUNTERWIDTH),
    .WAITTIME     (WAITTIME),
    .SCLK_DIV     (SCLK_DIV)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .cs_req(cs_req),
    .addr  (addr),
    .wdata (wdata),
    .MISO  (MISO),
    .MOSI  (MOSI),
    .SCLK  (SCLK),
    .CS    (CS),
    .rdata (rdata),
    .busy  (busy),
    .done  (done)
  );

  typedef struct {
    logic [15:0] mosi;
    logic [7:0]  rdata;
  } exp_t;

  exp_t       exp_q[$];
  int         tests_run;
  int         failures;
  int         rise_count;
  int         done_count;
  logic [7:0] model_rdata;
  logic [7:0] slave_byte;
  bit         glitch_en;

  logic        mon_prev_cs;
  logic        mon_prev_sclk;
  logic [15:0] mon_bits;
  int          mon_nbits;
  bit          mon_busy_pending;

  logic        slv_prev_sclk;
  int          slv_fall_cnt;
  int          slv_since_fall;
  logic        slv_bit;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (n >= budget) begin
      tests_run++;
      failures++;
      $display("[TB] FAIL idle_timeout: got busy=%0b pending=%0d, expected idle", busy,
               exp_q.size());
      exp_q.delete();
    end
    repeat (12) @(negedge CLK);
  endtask

  // The reference: a write shifts out {addr,wdata}; a read shifts out {addr,0}
  // and returns the slave byte; rdata otherwise keeps its previous value.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] w,
                               input logic [7:0] sb, input int hold, input bit wait_done);
    exp_t e;
    @(negedge CLK);
    addr       = a;
    wdata      = w;
    slave_byte = sb;
    if (a[7]) begin
      e.mosi      = {a, 8'h00};
      model_rdata = sb;
    end else begin
      e.mosi = {a, w};
    end
    e.rdata = model_rdata;
    exp_q.push_back(e);
    cs_req = 1'b1;
    repeat (hold) @(negedge CLK);
    cs_req = 1'b0;
    if (wait_done) waitIdle(3000);
  endtask

  initial begin
    int  dc0;
    int  rc0;
    int  n;
    bit  bad;
    reset       = 1'b1;
    cs_req      = 1'b0;
    addr        = 8'h00;
    wdata       = 8'h00;
    slave_byte  = 8'h00;
    glitch_en   = 1'b0;
    model_rdata = 8'h00;
    tests_run   = 0;
    failures    = 0;
    rise_count  = 0;
    done_count  = 0;

    fork
      begin : monitor
        mon_prev_cs      = 1'b1;
        mon_prev_sclk    = 1'b0;
        mon_bits         = '0;
        mon_nbits        = 0;
        mon_busy_pending = 1'b0;
        forever begin
          exp_t e;
          @(negedge CLK);
          if (CS === 1'b0 && mon_prev_cs === 1'b1) begin
            mon_bits  = '0;
            mon_nbits = 0;
          end
          if (SCLK === 1'b1 && mon_prev_sclk === 1'b0) begin
            if (CS !== 1'b0) checkOutput("sclk_rise_with_cs_high", 32'(CS), 32'd0);
            mon_bits = {mon_bits[14:0], MOSI};
            mon_nbits++;
            rise_count++;
          end
          if (mon_busy_pending) begin
            checkOutput("busy_after_done", 32'(busy), 32'd0);
            mon_busy_pending = 1'b0;
          end
          if (done === 1'b1) begin
            done_count++;
            if (exp_q.size() == 0) begin
              tests_run++;
              failures++;
              $display("[TB] FAIL unexpected_done: got done=1, expected no transaction");
            end else begin
              e = exp_q.pop_front();
              checkOutput("mosi_stream", 32'(mon_bits), 32'(e.mosi));
              checkOutput("sclk_periods", 32'(mon_nbits), 32'd16);
              checkOutput("rdata_at_done", 32'(rdata), 32'(e.rdata));
              checkOutput("cs_at_done", 32'(CS), 32'd1);
              checkOutput("sclk_at_done", 32'(SCLK), 32'd0);
            end
            mon_busy_pending = 1'b1;
          end
          mon_prev_cs   = CS;
          mon_prev_sclk = SCLK;
        end
      end
      begin : slave
        MISO           = 1'b0;
        slv_prev_sclk  = 1'b0;
        slv_fall_cnt   = 0;
        slv_since_fall = 0;
        slv_bit        = 1'b0;
        forever begin
          @(negedge CLK);
          if (CS !== 1'b0) begin
            slv_fall_cnt   = 0;
            slv_since_fall = 0;
            slv_bit        = 1'b0;
          end else if (slv_prev_sclk === 1'b1 && SCLK === 1'b0) begin
            slv_fall_cnt++;
            slv_since_fall = 0;
            if (slv_fall_cnt >= 8 && slv_fall_cnt <= 15) slv_bit = slave_byte[15 - slv_fall_cnt];
          end else begin
            slv_since_fall++;
          end
          MISO = (glitch_en && slv_fall_cnt == 11 && slv_since_fall == 4) ? ~slv_bit : slv_bit;
          slv_prev_sclk = SCLK;
        end
      end
      begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
      end
    join_none

    repeat (3) @(negedge CLK);
    checkOutput("reset_cs", 32'(CS), 32'd1);
    checkOutput("reset_sclk", 32'(SCLK), 32'd0);
    checkOutput("reset_mosi", 32'(MOSI), 32'd0);
    checkOutput("reset_rdata", 32'(rdata), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge CLK);

    // Request shorter than the debounce window must be filtered out.
    cs_req = 1'b1;
    repeat (WAITTIME - 1) @(negedge CLK);
    cs_req = 1'b0;
    bad = 1'b0;
    repeat (60) begin
      @(negedge CLK);
      if (CS !== 1'b1 || SCLK !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checkOutput("short_req_ignored", 32'(bad), 32'd0);
    checkOutput("short_req_no_done", 32'(done_count), 32'd0);

    applyStimulus(8'h05, 8'hA5, 8'h00, 10, 1'b1);
    checkOutput("write_keeps_rdata", 32'(rdata), 32'h00);
    applyStimulus(8'h83, 8'h00, 8'h3C, 10, 1'b1);
    checkOutput("read_rdata_held", 32'(rdata), 32'h3C);

    // A level held across several transaction lengths starts only one transaction.
    dc0 = done_count;
    applyStimulus(8'h12, 8'h34, 8'h00, 900, 1'b1);
    checkOutput("hold_high_one_done", 32'(done_count - dc0), 32'd1);
    dc0 = done_count;
    applyStimulus(8'h9A, 8'h00, 8'hC3, 10, 1'b1);
    checkOutput("retrigger_done", 32'(done_count - dc0), 32'd1);

    // Abort a write with reset after its fifth SCLK rise.
    dc0 = done_count;
    rc0 = rise_count;
    applyStimulus(8'h55, 8'h66, 8'h00, 10, 1'b0);
    n = 0;
    while (rise_count < rc0 + 5 && n < 3000) begin
      @(negedge CLK);
      #2;
      n++;
    end
    checkOutput("abort_reached_rise5", 32'(rise_count - rc0 >= 5), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("abort_cs", 32'(CS), 32'd1);
    checkOutput("abort_sclk", 32'(SCLK), 32'd0);
    checkOutput("abort_mosi", 32'(MOSI), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_rdata", 32'(rdata), 32'd0);
    exp_q.delete();
    model_rdata = 8'h00;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    repeat (5) @(negedge CLK);
    checkOutput("abort_no_done", 32'(done_count - dc0), 32'd0);
    applyStimulus(8'h21, 8'h7E, 8'h00, 10, 1'b1);

    // One-cycle MISO glitch inside a read of all ones.
    glitch_en = 1'b1;
    applyStimulus(8'hC4, 8'h00, 8'hFF, 10, 1'b1);
    glitch_en = 1'b0;
    checkOutput("glitch_rdata", 32'(rdata), 32'hFF);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(10, 20), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_frontend.md
Name: spi_master_frontend

Overview:
- Single-byte-address SPI master front end (mode 0, MSB first).
- Conditions the raw, asynchronous `cs_req` and `MISO` inputs: 2-flop synchronizer, debounce, edge detect.
- Runs the transaction FSM and a mux that picks the address or data byte for the transmit shift register.
- Generates `SCLK`, `CS` and `MOSI` toward an SPI slave and returns read data to the requesting logic.

Parameters:
- COUNTERWIDTH, 3, width of each conditioner's debounce counter.
- WAITTIME, 3, number of CLK cycles a synchronized input must stay stable before the conditioned output changes.
- SCLK_DIV, 8, CLK cycles per SCLK half-period. Must be >= WAITTIME+4.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cs_req  in  1  raw transaction request, active high; conditioned internally.
- addr  in  8  bit7 = R/W (1 = read, 0 = write), bits 6:0 = slave register address.
- wdata  in  8  write data byte.
- MISO  in  1  raw serial input from slave; conditioned internally.
- MOSI  out  1  serial output to slave.
- SCLK  out  1  serial clock; idles low.
- CS  out  1  slave chip select, active low; idles high.
- rdata  out  8  last byte read from the slave.
- busy  out  1  high from transaction start until done.
- done  out  1  one-cycle pulse at transaction end.

Behaviour:
- Reset (async): SCLK=0, CS=1, MOSI=0, rdata=0, busy=0, done=0. FSM goes to IDLE. Conditioner sync flops, counters and outputs all clear to 0.

Conditioner (one instance each for cs_req and MISO):
- 2-flop synchronizer.
- The conditioned output takes the synchronized value once that value has differed from the conditioned output for WAITTIME consecutive cycles. The counter resets whenever they match.
- Positive-edge and negative-edge outputs are one-cycle pulses, issued in the cycle the conditioned output changes.
- A glitch shorter than WAITTIME cycles is never seen downstream.

FSM states: IDLE, LOAD_ADDR, SHIFT_ADDR, LOAD_DATA, SHIFT_DATA, READ_DATA, DONE.
- IDLE:
  - Only a cs_req conditioned positive-edge starts a transaction.
  - A level held high does not retrigger.
  - Edges arriving while busy are ignored.
- LOAD_ADDR (1 cycle):
  - Latch addr and wdata into holding registers.
  - Mux select = addr; parallel-load the 8-bit shift register.
  - CS=0, busy=1.
- SHIFT_ADDR, 8 bits:
  - MOSI = shift register bit7 and is valid for the whole low half-period before each SCLK rise.
  - SCLK rises after SCLK_DIV cycles low and falls after SCLK_DIV cycles high.
  - The shift register shifts left at each SCLK fall.
  - After the 8th fall, go to LOAD_DATA if latched addr[7]=0, else READ_DATA.
- LOAD_DATA (1 cycle): mux select = wdata holding register; parallel-load; then SHIFT_DATA.
- SHIFT_DATA: identical timing to SHIFT_ADDR.
- READ_DATA, 8 SCLK periods:
  - MOSI is forced to 0 (output enable off).
  - Conditioned MISO is sampled in the last CLK cycle of each SCLK high half-period and shifted MSB-first into a capture register.
  - After the 8th bit, copy the capture register to rdata.
- DONE (1 cycle): SCLK=0, CS=1, done=1, MOSI=0. busy drops in the following cycle; return to IDLE.
- Transaction length: exactly 16 SCLK periods. CS is low continuously from LOAD_ADDR through the last SCLK fall.
- rdata holds its value between transactions. Write transactions do not modify rdata.
- Reset mid-transaction aborts immediately: CS=1, SCLK=0, no done pulse.
- Mux: 2-to-1, 8 bits wide, select 0 = address holding register, 1 = data holding register. Purely combinational.

Test Plan:
- cs_req pulse of WAITTIME-1 cycles -> no transaction: CS stays 1, SCLK stays 0, busy stays 0.
- Write, addr=0x05, wdata=0xA5 -> MOSI sampled on 16 SCLK rises = 0000_0101 then 1010_0101; CS low throughout; one done pulse; rdata unchanged (0x00).
- Read, addr=0x83, slave model drives 0x3C MSB-first on SCLK falls -> MOSI = 1000_0011 then 0 for 8 bits; rdata=0x3C at done.
- cs_req held high for 3 transaction lengths -> exactly one transaction and one done pulse. Toggle cs_req low then high -> second transaction runs.
- Assert reset after the 5th SCLK rise of a write -> CS=1, SCLK=0, MOSI=0 immediately; busy=0; no done pulse. A new request then completes normally.
- MISO glitch of 1 CLK cycle in mid-bit during a read of 0xFF -> rdata=0xFF, not corrupted.
